// File: rtl/mem_requester_pkg.sv
// Shared encodings for the memory requester; the hazard unit imports the same state codes.
package mem_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ERR    = 2'b10
  } state_e;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_requester_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)                  cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mem_requester.sv
// Pipeline-side initiator for mem_system: one outstanding load/store, sticky error,
// watchdog timeout and hit/miss performance counters.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_DataIn,
  output logic              mem_Rd,
  output logic              mem_Wr,
  input  logic [DATA_W-1:0] mem_DataOut,
  input  logic              mem_Done,
  input  logic              mem_Stall,
  input  logic              mem_CacheHit,
  input  logic              mem_err
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e   state, state_n;
  mem_req_t req_q;
  logic [7:0] wdog;
  logic accept, done_ok, in_access;

  // Completion is judged on mem_Done alone; stall is just visibility for the pipeline.
  logic stall_unused;
  assign stall_unused = mem_Stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      wdog       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_n;
      resp_valid <= done_ok;
      if (accept) req_q <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
      if (done_ok && !req_q.wr) resp_rdata <= mem_DataOut;
      // Zero everywhere outside ACCESS, so it starts at 0 on every entry.
      wdog <= (state == ACCESS) ? wdog + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[0]) state_n = ERR;
          else begin
            accept  = 1'b1;
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_err) state_n = ERR;
        else if (mem_Done) begin
          done_ok = 1'b1;
          state_n = IDLE;
        end else if (wdog == WD_LAST) state_n = ERR;
      end
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  assign in_access  = (state == ACCESS);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign err        = (state == ERR);
  assign mem_Rd     = in_access & ~req_q.wr;
  assign mem_Wr     = in_access &  req_q.wr;
  assign mem_Addr   = in_access ? req_q.addr  : '0;
  assign mem_DataIn = in_access ? req_q.wdata : '0;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .clr (rst),
    .inc (done_ok & mem_CacheHit),
    .cnt (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .clr (rst),
    .inc (done_ok & ~mem_CacheHit),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: scoreboard queue of expected read data, checked by a monitor on resp_valid.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, busy, resp_valid, err;
  logic [15:0] resp_rdata;
  logic [1:0]  hit_cnt, miss_cnt;
  logic [15:0] mem_Addr, mem_DataIn, mem_DataOut;
  logic        mem_Rd, mem_Wr, mem_Done, mem_Stall, mem_CacheHit, mem_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  mem_requester #(.TIMEOUT(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
    .mem_CacheHit(mem_CacheHit), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expected read data.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_resp: got rdata %0h want no response", resp_rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (resp_rdata !== e) begin
          n_bad++;
          $display("FAIL resp_rdata: got %0h want %0h", resp_rdata, e);
        end
      end
    end
  end

  task automatic clr_mem;
    mem_Done = 0; mem_CacheHit = 0; mem_err = 0; mem_Stall = 0; mem_DataOut = 16'h0;
  endtask

  task automatic do_reset;
    req_valid = 0; clr_mem();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
    chk({tag, "_miss_cnt"}, miss_cnt, 0);
    chk({tag, "_mem_rdwr"}, {mem_Rd, mem_Wr}, 0);
    chk({tag, "_mem_addr"}, mem_Addr, 0);
    chk({tag, "_mem_datain"}, mem_DataIn, 0);
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; clr_mem();
    tick(); tick();
    chk_reset_vals("reset");
    rst = 0;

    // Load hit at 0x0010, back-to-back with a store miss to 0x0400
    issue(0, 16'h0010, 16'h0);
    chk("hit_ready_c0", req_ready, 1);
    tick();
    req_valid = 0;
    chk("hit_rd_c1", {mem_Rd, mem_Wr}, 2'b10);
    chk("hit_addr_c1", mem_Addr, 16'h0010);
    chk("hit_busy_c1", busy, 1);
    mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    tick();
    clr_mem();
    chk("hit_resp_valid_c2", resp_valid, 1);
    chk("hit_cnt", hit_cnt, 1);
    chk("hit_rd_drop_c2", mem_Rd, 0);
    chk("b2b_ready_c2", req_ready, 1);
    issue(1, 16'h0400, 16'h1234);
    tick();
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("st_wr", {mem_Rd, mem_Wr}, 2'b01);
      chk("st_addr", mem_Addr, 16'h0400);
      chk("st_datain", mem_DataIn, 16'h1234);
      chk("st_busy", busy, 1);
      chk("st_ready", req_ready, 0);
      mem_Stall = (i < 4);
      if (i == 4) begin
        mem_Done = 1; mem_CacheHit = 0; mem_DataOut = 16'hDEAD;
        exp_q.push_back(16'hBEEF);
      end
      tick();
    end
    clr_mem();
    chk("st_miss_cnt", miss_cnt, 1);
    chk("st_hit_cnt", hit_cnt, 1);
    tick();
    chk("st_single_resp", resp_valid, 0);
    chk("st_rdata_kept", resp_rdata, 16'hBEEF);

    // Misaligned load
    do_reset();
    issue(0, 16'h0003, 16'h0);
    tick();
    issue(0, 16'h0010, 16'h0);
    chk("mis_err_c1", err, 1);
    chk("mis_rd_c1", mem_Rd, 0);
    chk("mis_ready_c1", req_ready, 0);
    chk("mis_busy_c1", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_err_held", err, 1);
      chk("mis_rd_held", {mem_Rd, mem_Wr}, 0);
      chk("mis_ready_held", req_ready, 0);
    end
    do_reset();
    chk("mis_err_cleared", err, 0);

    // Timeout with TIMEOUT=8: ERR at cycle 9
    issue(0, 16'h0020, 16'h0);
    tick();
    req_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      chk("to_no_err", err, 0);
      chk("to_rd", mem_Rd, 1);
      tick();
    end
    chk("to_err_c9", err, 1);
    chk("to_rd_c9", mem_Rd, 0);

    // mem_err together with mem_Done at cycle 3
    do_reset();
    issue(0, 16'h0040, 16'h0);
    tick();
    req_valid = 0;
    tick();
    tick();
    chk("me_noerr_c3", err, 0);
    mem_Done = 1; mem_err = 1; mem_CacheHit = 1; mem_DataOut = 16'h7777;
    tick();
    clr_mem();
    chk("me_err_c4", err, 1);
    chk("me_no_resp", resp_valid, 0);
    chk("me_hit_cnt", hit_cnt, 0);
    chk("me_miss_cnt", miss_cnt, 0);

    // Reset mid-access, then a normal load
    do_reset();
    issue(0, 16'h0080, 16'h0);
    tick();
    req_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk_reset_vals("midrst");
    issue(0, 16'h0030, 16'h0);
    tick();
    req_valid = 0;
    chk("midrst_addr", mem_Addr, 16'h0030);
    mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'h5555;
    exp_q.push_back(16'h5555);
    tick();
    clr_mem();
    chk("midrst_hit_cnt", hit_cnt, 1);
    chk("midrst_rdata", resp_rdata, 16'h5555);

    // Counter saturation: 5 hits on a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(0, 16'(16'h0100 + 2 * i), 16'h0);
      tick();
      req_valid = 0;
      mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'(16'hA000 + i);
      exp_q.push_back(16'(16'hA000 + i));
      tick();
      clr_mem();
    end
    tick();
    chk("sat_hit_cnt", hit_cnt, 3);
    chk("sat_miss_cnt", miss_cnt, 0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
# mem_requester

Pipeline-side initiator for the `mem_system` cache/memory interface. It accepts one load or store per handshake from the MEM or fetch stage. It registers the request, drives Addr/DataIn/Rd/Wr to the memory system and holds them stable until Done. It then returns read data with a one-cycle response pulse, and provides the pipeline stall, sticky error detection (misalignment, memory error, timeout) and hit/miss performance counters.

## Interface
- `TIMEOUT`, 64: cycles in ACCESS without `mem_Done` before the block declares an error (range 2..255).
- `CNT_W`, 16: width of the hit and miss counters.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  pipeline request strobe. Honoured only when `req_ready`=1.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  byte address. Must be even.
- `req_wdata`  in  16  store data.
- `req_ready`  out  1  block can accept a request.
- `busy`  out  1  stall to the pipeline.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  16  last load data.
- `err`  out  1  sticky error.
- `hit_cnt`  out  CNT_W  saturating count of completions with CacheHit.
- `miss_cnt`  out  CNT_W  saturating count of completions without CacheHit.
- `mem_Addr`  out  16  to the memory system's Addr.
- `mem_DataIn`  out  16  to the memory system's DataIn.
- `mem_Rd`  out  1  to the memory system's Rd.
- `mem_Wr`  out  1  to the memory system's Wr.
- `mem_DataOut`  in  16  from the memory system.
- `mem_Done`  in  1  from the memory system.
- `mem_Stall`  in  1  from the memory system.
- `mem_CacheHit`  in  1  from the memory system.
- `mem_err`  in  1  from the memory system.

## Operation
- **States:** IDLE, ACCESS, ERR.
- **IDLE:** `req_ready`=1, `mem_Rd`=`mem_Wr`=0.
  - `req_valid` with `req_addr[0]`=0: latch addr, wdata and wr; go to ACCESS.
  - `req_valid` with `req_addr[0]`=1: go to ERR. No memory access is issued.
- **ACCESS:** `busy`=1.
  - `mem_Rd`=~wr_q, `mem_Wr`=wr_q.
  - `mem_Addr` and `mem_DataIn` are driven from the latched registers. They are constant for the whole state.
- **ACCESS, on `mem_Done`=1:**
  - go to IDLE;
  - `resp_valid`=1 in the next cycle;
  - if a load, `resp_rdata` <= `mem_DataOut`; a store leaves `resp_rdata` unchanged;
  - increment `hit_cnt` if `mem_CacheHit`=1, otherwise increment `miss_cnt`.
- **ACCESS, on `mem_err`=1:** go to ERR. This takes priority over `mem_Done` in the same cycle; no response and no count.
- **ACCESS, timeout:** the watchdog counts cycles in ACCESS. It resets on entry. When it reaches `TIMEOUT` without `mem_Done`, go to ERR.
- **ERR:** absorbing until `rst`. `err`=1, `req_ready`=0, `busy`=1, `mem_Rd`=`mem_Wr`=0.
- **Ignored input:** `req_valid` while `req_ready`=0 is ignored. The pipeline holds its request.
- **`mem_Stall`:** informational only. Completion is signalled solely by `mem_Done`.
- **Counters:** saturate at all-ones and never wrap.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; `busy`=0; `resp_valid`=0; `resp_rdata`=0; `err`=0; counters 0; `mem_*` outputs 0.
- **Issue:** request accepted at cycle N; `mem_Rd`/`mem_Wr` asserted from cycle N+1.
- **Fastest completion:** a cache hit asserts `mem_Done` at N+1. `resp_valid` follows at N+2.
- **Throughput:** back-to-back hits are accepted every 2 cycles. The next request can be accepted in the same cycle as the previous `resp_valid`.
- **Request hold:** `mem_Rd`/`mem_Wr` stay high through the `mem_Done` cycle and drop in the following cycle.
- **Error:** `err` rises in the cycle after the triggering condition.
- **Timeout:** ERR is entered `TIMEOUT`+1 cycles after acceptance.
- **Reset mid-ACCESS:** `rst` at cycle M gives IDLE with all reset values at M+1. The in-flight request is dropped and no `resp_valid` is produced. The memory system shares `rst`.

## Structure
- **Shared package:** state encoding constants (IDLE=2'b00, ACCESS=2'b01, ERR=2'b10) and `DEFAULT_TIMEOUT`. The pipeline hazard unit reuses them.
- **Sub-module `sat_counter`** (width parameter, `inc`, synchronous clear):
  - instantiated twice, for the hit and miss counters;
  - the watchdog uses a plain 8-bit counter inside the FSM.
- **Flops:** all state is in flops with synchronous reset. Outputs are decoded from state and registers only; no input-to-output combinational paths.

## Test plan
- **Load hit:** load at 0x0010 accepted at cycle 0; memory model asserts Done+CacheHit at cycle 1 with DataOut=0xBEEF.
  - Required: `mem_Rd`=1 and `mem_Addr`=0x0010 at cycle 1; `resp_valid`=1 and `resp_rdata`=0xBEEF at cycle 2; `hit_cnt`=1.
- **Store miss:** store 0x1234 to 0x0400; Done without CacheHit after 5 cycles.
  - Required: `mem_Wr`/`mem_Addr`/`mem_DataIn` stable for all 5 cycles; `busy`=1; a single `resp_valid`; `miss_cnt`=1; `resp_rdata` unchanged.
- **Misaligned load:** `req_addr`=0x0003.
  - Required: `mem_Rd` never asserted; `err`=1 from cycle 1; `req_ready`=0 until `rst`.
- **Timeout / memory error:**
  - With `TIMEOUT`=8 and no Done: ERR at cycle 9.
  - Separately, `mem_err` and `mem_Done` asserted together at cycle 3: ERR, no `resp_valid`, counters unchanged.
- **Reset mid-access:** `rst` at cycle 2 of a miss.
  - Required: all outputs at reset values at cycle 3; a new load then completes normally.
- **Counter saturation:** `CNT_W`=2 with 5 consecutive hits.
  - Required: `hit_cnt`=3; `miss_cnt`=0.
